fft_ctrl: RTL and testbench

FFT_CTRL -- requirements
Module: fft_ctrl

---
 rtl/fft_pkg.sv | 36 +++
 rtl/fft_addr_gen.sv | 35 +++
 rtl/fft_ctrl.sv | 164 ++++++++++++++++
 tb/tb_fft_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared types and constants for the in-place radix-2 FFT controller.
// Contents: controller state encoding, data/angle widths, {x, y} field slices.
// Helper pack_xy builds a data word from its two components.
package fft_pkg;

    localparam int DATA_W  = 32;
    localparam int ANGLE_W = 32;
    localparam int COMP_W  = 16;

    // Field slices of a complex sample word {x, y}
    localparam int X_MSB = 31;
    localparam int X_LSB = 16;
    localparam int Y_MSB = 15;
    localparam int Y_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        RDA,
        RDB,
        LDB,
        WAIT,
        WRA,
        WRB,
        NEXT
    } fft_state_t;

    function automatic logic [DATA_W-1:0] pack_xy(input logic [COMP_W-1:0] x,
                                                  input logic [COMP_W-1:0] y);
        logic [DATA_W-1:0] w;
        w = '0;
        w[X_MSB:X_LSB] = x;
        w[Y_MSB:Y_LSB] = y;
        return w;
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: butterfly address / twiddle index generator for radix-2 DIF order.
// Inputs: stage, group, j counters. Outputs: operand addresses a, b, twiddle index k,
// last_in_stage (final butterfly of this stage), last_overall (final butterfly of the transform).
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = 4
) (
    input  logic [LOG2N-1:0] stage,
    input  logic [LOG2N-1:0] group,
    input  logic [LOG2N-1:0] j,
    output logic [LOG2N-1:0] a,
    output logic [LOG2N-1:0] b,
    output logic [LOG2N-1:0] k,
    output logic             last_in_stage,
    output logic             last_overall
);

    localparam int N = 1 << LOG2N;

    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] last_group;

    assign half       = LOG2N'(N >> (int'(stage) + 1));
    assign last_group = LOG2N'((1 << int'(stage)) - 1);

    // group * 2 * half == group << (LOG2N - stage)
    assign a = LOG2N'((int'(group) << (LOG2N - int'(stage))) + int'(j));
    assign b = a + half;
    assign k = LOG2N'(int'(j) << int'(stage));

    assign last_in_stage = (j == half - LOG2N'(1)) && (group == last_group);
    assign last_overall  = last_in_stage && (stage == LOG2N'(LOG2N - 1));

endmodule

// File: rtl/fft_ctrl.sv
// fft_ctrl: sequencer for an in-place radix-2 DIF FFT over a single-port sample RAM
// and an external fixed-latency butterfly. Ports: start/busy/done handshake, RAM
// address/we/wdata/rdata, butterfly operands bf_a/bf_b/bf_zangle and results bf_out1/bf_out2.
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int LOG2N      = 4,
    parameter int CORDIC_LAT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [LOG2N-1:0]   mem_addr,
    output logic               mem_we,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic [DATA_W-1:0]  bf_a,
    output logic [DATA_W-1:0]  bf_b,
    output logic [ANGLE_W-1:0] bf_zangle,
    input  logic [DATA_W-1:0]  bf_out1,
    input  logic [DATA_W-1:0]  bf_out2
);

    localparam int WCW = $clog2(CORDIC_LAT + 1);

    fft_state_t       state;
    logic [LOG2N-1:0] stage;
    logic [LOG2N-1:0] group;
    logic [LOG2N-1:0] j;
    logic [WCW-1:0]   wcnt;

    logic [LOG2N-1:0]   addr_a;
    logic [LOG2N-1:0]   addr_b;
    logic [LOG2N-1:0]   k;
    logic               last_in_stage;
    logic               last_overall;
    logic               j_last;
    logic [ANGLE_W-1:0] k_turn;
    logic [ANGLE_W-1:0] zangle_nxt;

    fft_addr_gen #(
        .LOG2N(LOG2N)
    ) u_addr_gen (
        .stage        (stage),
        .group        (group),
        .j            (j),
        .a            (addr_a),
        .b            (addr_b),
        .k            (k),
        .last_in_stage(last_in_stage),
        .last_overall (last_overall)
    );

    // b - a is the butterfly span (half), so j has reached its last value at half-1
    assign j_last = (j == addr_b - addr_a - LOG2N'(1));

    // Twiddle is -k/N of a turn in 32-bit binary angle units
    assign k_turn     = {k, {(ANGLE_W - LOG2N){1'b0}}};
    assign zangle_nxt = -k_turn;

    // Write data follows the butterfly result live in WRA/WRB: the results only
    // become valid CORDIC_LAT cycles after WAIT begins, i.e. at the start of WRA.
    always_comb begin
        mem_wdata = '0;
        case (state)
            WRA:     mem_wdata = bf_out1;
            WRB:     mem_wdata = bf_out2;
            default: mem_wdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            stage     <= '0;
            group     <= '0;
            j         <= '0;
            wcnt      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            bf_a      <= '0;
            bf_b      <= '0;
            bf_zangle <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RDA;
                        busy      <= 1'b1;
                        mem_addr  <= addr_a;
                        bf_zangle <= zangle_nxt;
                    end
                end
                RDA: begin
                    state    <= RDB;
                    mem_addr <= addr_b;
                end
                RDB: begin
                    // RAM now returns the word at a
                    state    <= LDB;
                    mem_addr <= '0;
                    bf_a     <= mem_rdata;
                end
                LDB: begin
                    state <= WAIT;
                    bf_b  <= mem_rdata;
                    wcnt  <= '0;
                end
                WAIT: begin
                    if (wcnt == WCW'(CORDIC_LAT - 1)) begin
                        state    <= WRA;
                        mem_addr <= addr_a;
                        mem_we   <= 1'b1;
                    end else begin
                        wcnt <= wcnt + WCW'(1);
                    end
                end
                WRA: begin
                    state    <= WRB;
                    mem_addr <= addr_b;
                end
                WRB: begin
                    // Counters advance here so the next a/k are ready on leaving NEXT
                    state    <= NEXT;
                    mem_we   <= 1'b0;
                    mem_addr <= '0;
                    if (last_overall) begin
                        stage <= '0;
                        group <= '0;
                        j     <= '0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (last_in_stage) begin
                        stage <= stage + LOG2N'(1);
                        group <= '0;
                        j     <= '0;
                    end else if (j_last) begin
                        group <= group + LOG2N'(1);
                        j     <= '0;
                    end else begin
                        j <= j + LOG2N'(1);
                    end
                end
                NEXT: begin
                    // done is high only during the final NEXT
                    if (done) begin
                        state <= IDLE;
                    end else begin
                        state     <= RDA;
                        mem_addr  <= addr_a;
                        bf_zangle <= zangle_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_ctrl.sv
// tb_fft_ctrl: randomized self-checking bench for fft_ctrl (N=16, CORDIC_LAT=16)
// with a sample RAM, an add/subtract butterfly stub and a loop-level FFT-order model.
module tb_fft_ctrl;

    localparam int LOG2N = 4;
    localparam int N     = 16;
    localparam int LAT   = 16;
    localparam int RUN   = LOG2N * (N / 2) * (LAT + 6);

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic             busy, done, mem_we;
    logic [LOG2N-1:0] mem_addr;
    logic [31:0]      mem_wdata, mem_rdata, bf_a, bf_b, bf_zangle, bf_out1, bf_out2;
    logic [3+LOG2N+128-1:0] all_outs;

    int total = 0;
    int bad   = 0;

    fft_ctrl #(.LOG2N(LOG2N), .CORDIC_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .bf_a(bf_a), .bf_b(bf_b), .bf_zangle(bf_zangle), .bf_out1(bf_out1), .bf_out2(bf_out2)
    );

    always #5 clk = ~clk;

    assign all_outs = {busy, done, mem_we, mem_addr, mem_wdata, bf_a, bf_b, bf_zangle};

    function automatic logic [31:0] cadd(input logic [31:0] p, input logic [31:0] q);
        return {p[31:16] + q[31:16], p[15:0] + q[15:0]};
    endfunction

    function automatic logic [31:0] csub(input logic [31:0] p, input logic [31:0] q);
        return {p[31:16] - q[31:16], p[15:0] - q[15:0]};
    endfunction

    // Sample RAM: read data one cycle after address; bulk preload on load_req
    logic [31:0] ram[N];
    logic [31:0] img_init[N];
    logic        load_req = 1'b0;
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < N; i++) ram[i] <= img_init[i];
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    // Butterfly stub: LAT-deep pipeline, angle ignored
    logic [31:0] p1[LAT];
    logic [31:0] p2[LAT];
    always @(posedge clk) begin
        p1[0] <= cadd(bf_a, bf_b);
        p2[0] <= csub(bf_a, bf_b);
        for (int i = 1; i < LAT; i++) begin
            p1[i] <= p1[i-1];
            p2[i] <= p2[i-1];
        end
    end
    assign bf_out1 = p1[LAT-1];
    assign bf_out2 = p2[LAT-1];

    // Reference model state and observed trace
    logic [31:0]      mdl[N];
    logic [LOG2N-1:0] exp_addr_q[$];
    logic [31:0]      exp_ang_q[$];
    logic [LOG2N-1:0] obs_addr_q[$];
    logic [31:0]      obs_ang_q[$];
    int               done_cnt, done_cyc, busy_err;
    logic [LOG2N-1:0] rd0, rd1;

    task automatic load_image();
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
    endtask

    task automatic random_image();
        for (int i = 0; i < N; i++) img_init[i] = $urandom;
        load_image();
    endtask

    // Walk the DIF loop nest directly: expected write trace, twiddles and final RAM
    task automatic build_model();
        int half, a, b, k;
        logic [31:0] t, ang;
        exp_addr_q.delete();
        exp_ang_q.delete();
        for (int i = 0; i < N; i++) mdl[i] = ram[i];
        for (int s = 0; s < LOG2N; s++) begin
            half = N >> (s + 1);
            for (int g = 0; g < N / (2 * half); g++) begin
                for (int jj = 0; jj < half; jj++) begin
                    a = g * 2 * half + jj;
                    b = a + half;
                    k = jj << s;
                    ang = 32'(((longint'(N - k) % N) << 32) / N);
                    exp_addr_q.push_back(LOG2N'(a));
                    exp_addr_q.push_back(LOG2N'(b));
                    exp_ang_q.push_back(ang);
                    exp_ang_q.push_back(ang);
                    t = cadd(mdl[a], mdl[b]);
                    mdl[b] = csub(mdl[a], mdl[b]);
                    mdl[a] = t;
                end
            end
        end
    endtask

    // Pulse start and follow the transform, recording writes and done; bounded by RUN+40
    task automatic run_fft(input int s1, input int s2, input bit start_on_done, input int rst_at);
        int n;
        bit dseen;
        obs_addr_q.delete();
        obs_ang_q.delete();
        done_cnt = 0; done_cyc = -1; busy_err = 0; dseen = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 1;
        while (n <= RUN + 40) begin
            if (n == 1) rd0 = mem_addr;
            if (n == 2) rd1 = mem_addr;
            if (mem_we) begin
                obs_addr_q.push_back(mem_addr);
                obs_ang_q.push_back(bf_zangle);
            end
            if (done) begin
                done_cnt++;
                done_cyc = n;
                dseen = 1;
                if (busy) busy_err++;
            end else if (dseen == busy) begin
                busy_err++;
            end
            if (rst_at == n) begin
                rst_n = 1'b0;
                return;
            end
            start = (n == s1) || (n == s2) || (start_on_done && done);
            if (dseen && n >= done_cyc + 6) break;
            @(posedge clk);
            #1 n++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        int idle_err;
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (all_outs !== '0) begin
            bad++; $display("FAIL reset_outputs actual=%h required=0", all_outs);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_err = 0;
        repeat (8) begin
            @(posedge clk);
            #1 if (busy || mem_we || done || mem_addr != 0) idle_err++;
        end
        total++;
        if (idle_err !== 0) begin
            bad++; $display("FAIL idle_after_reset actual=%0d active cycles required=0", idle_err);
        end
    endtask

    task automatic test_impulse();
        int err;
        for (int i = 0; i < N; i++) img_init[i] = 32'h0;
        img_init[0] = {16'd100, 16'd0};
        load_image();
        build_model();
        run_fft(0, 0, 1'b0, 0);
        total++;
        if (rd0 !== 0 || rd1 !== 8) begin
            bad++; $display("FAIL impulse_first_reads actual=%0d/%0d required=0/8", rd0, rd1);
        end
        total++;
        if (done_cnt !== 1 || done_cyc !== RUN) begin
            bad++; $display("FAIL impulse_done actual=cnt %0d cyc %0d required=cnt 1 cyc %0d", done_cnt, done_cyc, RUN);
        end
        total++;
        if (busy_err !== 0) begin
            bad++; $display("FAIL impulse_busy actual=%0d bad cycles required=0", busy_err);
        end
        total++;
        if (obs_addr_q.size() != 64) begin
            bad++; $display("FAIL impulse_write_count actual=%0d required=64", obs_addr_q.size());
        end else begin
            total++;
            if (obs_addr_q[0] !== 0 || obs_addr_q[1] !== 8 || obs_ang_q[0] !== 32'h0) begin
                bad++; $display("FAIL bfly0 actual=%0d/%0d ang %h required=0/8 ang 0", obs_addr_q[0], obs_addr_q[1], obs_ang_q[0]);
            end
            total++;
            if (obs_addr_q[2] !== 1 || obs_addr_q[3] !== 9 || obs_ang_q[2] !== 32'hF000_0000) begin
                bad++; $display("FAIL s0_j1 actual=%0d/%0d ang %h required=1/9 ang f0000000", obs_addr_q[2], obs_addr_q[3], obs_ang_q[2]);
            end
            total++;
            if (obs_addr_q[18] !== 1 || obs_addr_q[19] !== 5 || obs_ang_q[18] !== 32'hE000_0000) begin
                bad++; $display("FAIL s1_j1 actual=%0d/%0d ang %h required=1/5 ang e0000000", obs_addr_q[18], obs_addr_q[19], obs_ang_q[18]);
            end
            err = 0;
            for (int g = 0; g < 8; g++) begin
                if (obs_addr_q[48 + 2*g] !== LOG2N'(2*g) || obs_addr_q[49 + 2*g] !== LOG2N'(2*g + 1) ||
                    obs_ang_q[48 + 2*g] !== 32'h0) err++;
            end
            total++;
            if (err !== 0) begin
                bad++; $display("FAIL last_stage_pairs actual=%0d wrong pairs required=0", err);
            end
        end
        err = 0;
        for (int i = 0; i < N; i++) if (ram[i] !== 32'h0064_0000) err++;
        total++;
        if (err !== 0) begin
            bad++; $display("FAIL impulse_result actual=%0d wrong words (ram[1]=%h) required=all 00640000", err, ram[1]);
        end
    endtask

    task automatic test_random_starts();
        int err;
        random_image();
        build_model();
        run_fft(10, 300, 1'b1, 0);
        total++;
        if (done_cnt !== 1 || done_cyc !== RUN || busy_err !== 0) begin
            bad++; $display("FAIL ignored_starts actual=cnt %0d cyc %0d busyerr %0d required=cnt 1 cyc %0d busyerr 0", done_cnt, done_cyc, busy_err, RUN);
        end
        err = 0;
        if (obs_addr_q.size() != exp_addr_q.size()) err = 999;
        else for (int i = 0; i < exp_addr_q.size(); i++)
            if (obs_addr_q[i] !== exp_addr_q[i] || obs_ang_q[i] !== exp_ang_q[i]) err++;
        total++;
        if (err !== 0) begin
            bad++; $display("FAIL random_trace actual=%0d mismatches (len %0d) required=0 (len %0d)", err, obs_addr_q.size(), exp_addr_q.size());
        end
        err = 0;
        for (int i = 0; i < N; i++) if (ram[i] !== mdl[i]) err++;
        total++;
        if (err !== 0) begin
            bad++; $display("FAIL random_result actual=%0d wrong words (ram[0]=%h) required=0 (mdl[0]=%h)", err, ram[0], mdl[0]);
        end
    endtask

    task automatic test_back_to_back();
        int err;
        random_image();
        for (int r = 0; r < 2; r++) begin
            build_model();
            run_fft(0, 0, 1'b0, 0);
            err = 0;
            if (obs_addr_q.size() != exp_addr_q.size()) err = 999;
            else for (int i = 0; i < exp_addr_q.size(); i++)
                if (obs_addr_q[i] !== exp_addr_q[i] || obs_ang_q[i] !== exp_ang_q[i]) err++;
            for (int i = 0; i < N; i++) if (ram[i] !== mdl[i]) err++;
            total++;
            if (err !== 0 || done_cyc !== RUN) begin
                bad++; $display("FAIL back_to_back run %0d actual=%0d mismatches cyc %0d required=0 cyc %0d", r, err, done_cyc, RUN);
            end
        end
    endtask

    task automatic test_reset_mid();
        int err;
        random_image();
        run_fft(0, 0, 1'b0, 150);
        #1;
        total++;
        if (all_outs !== '0) begin
            bad++; $display("FAIL midrun_reset_outputs actual=%h required=0", all_outs);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        err = 0;
        repeat (5) begin
            @(posedge clk);
            #1 if (busy || mem_we || done) err++;
        end
        total++;
        if (err !== 0) begin
            bad++; $display("FAIL idle_after_midrun_reset actual=%0d active cycles required=0", err);
        end
        build_model();
        run_fft(0, 0, 1'b0, 0);
        total++;
        if (rd0 !== 0 || rd1 !== 8 || done_cyc !== RUN) begin
            bad++; $display("FAIL restart actual=%0d/%0d cyc %0d required=0/8 cyc %0d", rd0, rd1, done_cyc, RUN);
        end
        err = 0;
        for (int i = 0; i < N; i++) if (ram[i] !== mdl[i]) err++;
        total++;
        if (err !== 0) begin
            bad++; $display("FAIL restart_result actual=%0d wrong words required=0", err);
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_random_starts();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
